// File: rtl/cv32e41s_obi_resp_integrity.sv
// OBI subordinate integrity front end: checks reqpar/achk, grants, drives a 1-cycle SRAM.
// Latency: accept in cycle N gives rvalid in N+2. Backpressure: gnt held low when full or gnt_stall_i.
module cv32e41s_obi_resp_integrity #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        integrity_en_i,
  input  logic        gnt_stall_i,
  input  logic        resp_stall_i,
  input  logic        obi_req_i,
  input  logic        obi_reqpar_i,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  input  logic [2:0]  obi_prot_i,
  input  logic [1:0]  obi_memtype_i,
  input  logic        obi_dbg_i,
  input  logic [11:0] obi_achk_i,
  output logic        obi_gnt_o,
  output logic        obi_gntpar_o,
  output logic        obi_rvalid_o,
  output logic        obi_rvalidpar_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic [4:0]  obi_rchk_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        reqpar_err_o,
  output logic        achk_err_o,
  output logic        protocol_err_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam int unsigned FW = 32 + 1 + 4 + 32 + 3 + 2 + 1 + 12;

  logic [11:0]   achk_calc;
  logic          reqpar_err, achk_err, accept, proto_err;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap_vld_q, cap_we_q, cap_err_q;
  logic [32:0]   push_dat, head;
  logic          push, pop;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] fcnt_q;
  logic [32:0]   fifo_q [MAX_OUTSTANDING];
  logic          pend_q;
  logic [FW-1:0] fld, fld_q;
  logic          reqpar_err_q, achk_err_q, proto_err_q;

  always_comb begin
    achk_calc = '0;
    for (int k = 0; k < 4; k++) begin
      achk_calc[k]     = ^obi_addr_i[8*k +: 8];
      achk_calc[8 + k] = ^obi_wdata_i[8*k +: 8];
    end
    achk_calc[4] = ^{obi_prot_i, obi_memtype_i};
    achk_calc[5] = ^{obi_be_i, obi_we_i};
    achk_calc[6] = obi_dbg_i;
  end

  assign reqpar_err   = (obi_reqpar_i == obi_req_i);
  assign obi_gnt_o    = !gnt_stall_i && (cnt_q < CNT_MAX);
  assign obi_gntpar_o = !obi_gnt_o;
  assign accept       = obi_req_i && obi_gnt_o;
  assign achk_err     = integrity_en_i && accept && (achk_calc != obi_achk_i);

  // Faulty requests still occupy a slot and get an error response, but never touch the SRAM.
  assign mem_req_o   = accept && !reqpar_err && !achk_err;
  assign mem_we_o    = obi_we_i;
  assign mem_addr_o  = obi_addr_i;
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q <= 1'b0;
      cap_we_q  <= 1'b0;
      cap_err_q <= 1'b0;
    end else begin
      cap_vld_q <= accept;
      cap_we_q  <= obi_we_i;
      cap_err_q <= reqpar_err || achk_err;
    end
  end

  assign push     = cap_vld_q;
  assign push_dat = {cap_err_q, (cap_we_q || cap_err_q) ? 32'h0 : mem_rdata_i};
  assign pop      = obi_rvalid_o;
  assign head     = fifo_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= push_dat;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, obi_rvalid_o})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign obi_rvalid_o    = (fcnt_q != '0) && !resp_stall_i;
  assign obi_rvalidpar_o = !obi_rvalid_o;
  assign obi_rdata_o     = obi_rvalid_o ? head[31:0] : 32'h0;
  assign obi_err_o       = obi_rvalid_o && head[32];

  always_comb begin
    obi_rchk_o = '0;
    if (obi_rvalid_o) begin
      for (int k = 0; k < 4; k++) obi_rchk_o[k] = ^head[8*k +: 8];
      obi_rchk_o[4] = ^{head[32], 1'b0};
    end
  end

  // A stalled request must stay asserted with all address-phase fields frozen.
  assign fld       = {obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_prot_i,
                      obi_memtype_i, obi_dbg_i, obi_achk_i};
  assign proto_err = pend_q && (!obi_req_i || (fld != fld_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      fld_q        <= '0;
      reqpar_err_q <= 1'b0;
      achk_err_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      pend_q       <= obi_req_i && !obi_gnt_o;
      fld_q        <= fld;
      reqpar_err_q <= reqpar_err;
      achk_err_q   <= achk_err;
      proto_err_q  <= proto_err;
    end
  end

  assign reqpar_err_o   = reqpar_err_q;
  assign achk_err_o     = achk_err_q;
  assign protocol_err_o = proto_err_q;

endmodule

// File: tb/tb_cv32e41s_obi_resp_integrity.sv
// Scoreboard bench: per-cycle reference model of grant, SRAM strobe, alarms and in-order responses.
module tb_cv32e41s_obi_resp_integrity;
  localparam int MAXO = 2;

  logic        clk, rst_n;
  logic        integrity_en_i, gnt_stall_i, resp_stall_i;
  logic        obi_req_i, obi_reqpar_i, obi_we_i, obi_dbg_i;
  logic [31:0] obi_addr_i, obi_wdata_i;
  logic [3:0]  obi_be_i;
  logic [2:0]  obi_prot_i;
  logic [1:0]  obi_memtype_i;
  logic [11:0] obi_achk_i;
  logic        obi_gnt_o, obi_gntpar_o, obi_rvalid_o, obi_rvalidpar_o, obi_err_o;
  logic [31:0] obi_rdata_o;
  logic [4:0]  obi_rchk_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        reqpar_err_o, achk_err_o, protocol_err_o;

  cv32e41s_obi_resp_integrity #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .integrity_en_i(integrity_en_i), .gnt_stall_i(gnt_stall_i),
    .resp_stall_i(resp_stall_i), .obi_req_i(obi_req_i), .obi_reqpar_i(obi_reqpar_i),
    .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_prot_i(obi_prot_i), .obi_memtype_i(obi_memtype_i), .obi_dbg_i(obi_dbg_i),
    .obi_achk_i(obi_achk_i), .obi_gnt_o(obi_gnt_o), .obi_gntpar_o(obi_gntpar_o),
    .obi_rvalid_o(obi_rvalid_o), .obi_rvalidpar_o(obi_rvalidpar_o), .obi_rdata_o(obi_rdata_o),
    .obi_err_o(obi_err_o), .obi_rchk_o(obi_rchk_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .reqpar_err_o(reqpar_err_o), .achk_err_o(achk_err_o),
    .protocol_err_o(protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [11:0] calc_achk(input logic [31:0] a, input logic we, input logic [3:0] be,
                                            input logic [31:0] wd, input logic [2:0] pr,
                                            input logic [1:0] mt, input logic dbg);
    logic [11:0] c;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[k]     = ^a[8*k +: 8];
      c[8 + k] = ^wd[8*k +: 8];
    end
    c[4] = ^{pr, mt};
    c[5] = ^{be, we};
    c[6] = dbg;
    return c;
  endfunction

  // SRAM model driven by the DUT strobe; returns garbage when not read so stray captures show up.
  logic [31:0] sram    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_req_o && mem_we_o) begin
      w = sram.exists(mem_addr_o) ? sram[mem_addr_o] : dflt(mem_addr_o);
      for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
      sram[mem_addr_o] = w;
    end
    if (mem_req_o && !mem_we_o)
      mem_rdata_i <= sram.exists(mem_addr_o) ? sram[mem_addr_o] : dflt(mem_addr_o);
    else
      mem_rdata_i <= $urandom;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t q[$];

  int          cyc = 0;
  int          mcnt = 0;
  bit          pend = 0, exp_rq = 0, exp_ac = 0, exp_pr = 0;
  logic [86:0] pfld = '0;

  always @(negedge clk) begin
    bit          exp_gnt, acc, rq_now, ac_now, pr_now, exp_rv;
    logic [86:0] fld_now;
    exp_t        e;
    logic [31:0] w;
    if (!rst_n) begin
      chk("rst_rvalid", 64'(obi_rvalid_o), 64'd0);
      chk("rst_rvalidpar", 64'(obi_rvalidpar_o), 64'd1);
      chk("rst_gnt", 64'(obi_gnt_o), 64'(!gnt_stall_i));
      q.delete();
      mcnt = 0; pend = 0; exp_rq = 0; exp_ac = 0; exp_pr = 0; pfld = '0;
    end else begin
      exp_gnt = !gnt_stall_i && (mcnt < MAXO);
      chk("gnt", 64'(obi_gnt_o), 64'(exp_gnt));
      chk("gntpar", 64'(obi_gntpar_o), 64'(!exp_gnt));
      chk("reqpar_err", 64'(reqpar_err_o), 64'(exp_rq));
      chk("achk_err", 64'(achk_err_o), 64'(exp_ac));
      chk("protocol_err", 64'(protocol_err_o), 64'(exp_pr));

      rq_now = (obi_reqpar_i == obi_req_i);
      acc    = obi_req_i && exp_gnt;
      ac_now = integrity_en_i && acc &&
               (obi_achk_i != calc_achk(obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
                                        obi_prot_i, obi_memtype_i, obi_dbg_i));
      chk("mem_req", 64'(mem_req_o), 64'(acc && !rq_now && !ac_now));
      if (mem_req_o)
        chk("mem_mirror", {mem_addr_o, mem_be_o, mem_we_o, 27'd0},
                          {obi_addr_i, obi_be_i, obi_we_i, 27'd0});

      exp_rv = (q.size() > 0) && (q[0].acc + 2 <= cyc) && !resp_stall_i;
      chk("rvalid", 64'(obi_rvalid_o), 64'(exp_rv));
      chk("rvalidpar", 64'(obi_rvalidpar_o), 64'(!exp_rv));
      if (obi_rvalid_o && q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", 64'(obi_rdata_o), 64'(e.rdata));
        chk("err", 64'(obi_err_o), 64'(e.err));
        chk("rchk", 64'(obi_rchk_o), 64'({e.err, ^e.rdata[31:24], ^e.rdata[23:16],
                                               ^e.rdata[15:8], ^e.rdata[7:0]}));
      end else if (!obi_rvalid_o) begin
        chk("idle_resp", 64'({obi_rdata_o, obi_err_o, obi_rchk_o}), 64'd0);
      end

      if (acc) begin
        e.acc = cyc;
        e.err = rq_now || ac_now;
        e.rdata = '0;
        if (!e.err && !obi_we_i) begin
          e.rdata = ref_mem.exists(obi_addr_i) ? ref_mem[obi_addr_i] : dflt(obi_addr_i);
        end else if (!e.err) begin
          w = ref_mem.exists(obi_addr_i) ? ref_mem[obi_addr_i] : dflt(obi_addr_i);
          for (int b = 0; b < 4; b++) if (obi_be_i[b]) w[8*b +: 8] = obi_wdata_i[8*b +: 8];
          ref_mem[obi_addr_i] = w;
        end
        q.push_back(e);
      end

      fld_now = {obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_prot_i,
                 obi_memtype_i, obi_dbg_i, obi_achk_i};
      pr_now  = pend && (!obi_req_i || fld_now != pfld);
      mcnt    = mcnt + int'(acc) - int'(exp_rv);
      pend    = obi_req_i && !exp_gnt;
      pfld    = fld_now;
      exp_rq  = rq_now;
      exp_ac  = ac_now;
      exp_pr  = pr_now;
    end
    cyc++;
  end

  task automatic drive(input bit req, input logic [31:0] addr, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, input logic [11:0] flip, input bit bad_par,
                       output bit granted);
    obi_req_i    = req;
    obi_addr_i   = addr;
    obi_we_i     = we;
    obi_be_i     = be;
    obi_wdata_i  = wd;
    obi_achk_i   = calc_achk(addr, we, be, wd, obi_prot_i, obi_memtype_i, obi_dbg_i) ^ flip;
    obi_reqpar_i = bad_par ? req : !req;
    @(negedge clk);
    granted = req && obi_gnt_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) drive(0, 32'h0, 0, 4'h0, 32'h0, 12'h0, 0, g);
  endtask

  // Holds a request until granted; resp_stall_i is dropped after three refused cycles.
  task automatic issue(input logic [31:0] addr, input bit we, input logic [31:0] wd);
    bit g;
    g = 0;
    for (int k = 0; k < 20 && !g; k++) begin
      if (k == 3) resp_stall_i = 0;
      drive(1, addr, we, 4'hF, wd, 12'h0, 0, g);
    end
    if (!g) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bit          g, r, we, bp;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic [11:0] fl;
    rst_n = 0; integrity_en_i = 1; gnt_stall_i = 0; resp_stall_i = 0;
    obi_prot_i = 3'b011; obi_memtype_i = 2'b00; obi_dbg_i = 0;
    obi_req_i = 0; obi_reqpar_i = 1; obi_addr_i = 0; obi_we_i = 0; obi_be_i = 0;
    obi_wdata_i = 0; obi_achk_i = 0;
    sram[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(2);

    drive(1, 32'h100, 0, 4'hF, 32'h0, 12'h0, 0, g);
    idle(4);

    resp_stall_i = 1;
    issue(32'h0, 0, 32'h0);
    issue(32'h4, 0, 32'h0);
    issue(32'h8, 0, 32'h0);
    idle(5);

    drive(1, 32'h20, 1, 4'hF, 32'h12345678, 12'h200, 0, g);
    idle(3);
    issue(32'h20, 0, 32'h0);
    idle(3);

    drive(0, 32'h0, 0, 4'h0, 32'h0, 12'h0, 1, g);
    idle(3);

    gnt_stall_i = 1;
    drive(1, 32'h10, 0, 4'hF, 32'h0, 12'h0, 0, g);
    drive(1, 32'h14, 0, 4'hF, 32'h0, 12'h0, 0, g);
    gnt_stall_i = 0;
    drive(1, 32'h14, 0, 4'hF, 32'h0, 12'h0, 0, g);
    idle(4);

    resp_stall_i = 1;
    issue(32'h30, 1, 32'hCAFEF00D);
    issue(32'h34, 0, 32'h0);
    resp_stall_i = 1;
    idle(2);
    rst_n = 0;
    idle(2);
    rst_n = 1;
    resp_stall_i = 0;
    issue(32'h100, 0, 32'h0);
    idle(5);

    r = 0; a = 0; we = 0; be = 0; wd = 0; fl = 0; bp = 0; g = 1;
    for (int i = 0; i < 1500; i++) begin
      gnt_stall_i  = ($urandom_range(0, 3) == 0);
      resp_stall_i = ($urandom_range(0, 2) == 0);
      if (!(r && !g) || $urandom_range(0, 15) == 0) begin
        if (i % 50 == 0) integrity_en_i = 1'($urandom_range(0, 1));
        r  = ($urandom_range(0, 2) != 0);
        a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        we = 1'($urandom_range(0, 1));
        be = 4'($urandom_range(0, 15));
        wd = $urandom;
        fl = ($urandom_range(0, 7) == 0) ? (12'h1 << $urandom_range(0, 11)) : 12'h0;
        bp = ($urandom_range(0, 15) == 0);
        obi_prot_i    = 3'($urandom_range(0, 7));
        obi_memtype_i = 2'($urandom_range(0, 3));
        obi_dbg_i     = 1'($urandom_range(0, 1));
      end
      drive(r, a, we, be, wd, fl, bp, g);
    end

    gnt_stall_i = 0;
    resp_stall_i = 0;
    for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
    chk("drain_empty", 64'(q.size()), 64'd0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
